fetch_inst_queue: RTL

- Circular instruction queue directly downstream of the fetch-to-decode pipeline register; feeds the decode stage.
- Each cycle it accepts up to 4 fetched packets with per-lane valid bits, compacts them in program order, and presents up to 4 oldest packets to decode.
- Decouples fetch bubbles and decode stalls.
- Provides registered-state back-pressure (stall_o) to the fetch-to-decode register.

---
 rtl/fetch_inst_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_inst_queue.sv
// Circular instruction queue between the fetch-to-decode register and decode.
// Compacts up to four valid lanes per cycle and presents the four oldest entries.
module fetch_inst_queue #(
  parameter int DEPTH     = 16,
  parameter int PKT_W     = 131,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instruction0Valid_i,
  input  logic                 instruction1Valid_i,
  input  logic                 instruction2Valid_i,
  input  logic                 instruction3Valid_i,
  input  logic [PKT_W-1:0]     inst0Packet_i,
  input  logic [PKT_W-1:0]     inst1Packet_i,
  input  logic [PKT_W-1:0]     inst2Packet_i,
  input  logic [PKT_W-1:0]     inst3Packet_i,
  input  logic                 flush_i,
  input  logic                 decodeStall_i,
  output logic                 instruction0Valid_o,
  output logic                 instruction1Valid_o,
  output logic                 instruction2Valid_o,
  output logic                 instruction3Valid_o,
  output logic [PKT_W-1:0]     inst0Packet_o,
  output logic [PKT_W-1:0]     inst1Packet_o,
  output logic [PKT_W-1:0]     inst2Packet_o,
  output logic [PKT_W-1:0]     inst3Packet_o,
  output logic                 stall_o,
  output logic [DEPTH_LOG:0]   count_o
);

  localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] FOUR_C  = (DEPTH_LOG+1)'(4);

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Saturates the dequeue amount at the four decode slots.
  function automatic logic [2:0] deq_limit(input logic [DEPTH_LOG:0] cnt);
    return (cnt > FOUR_C) ? 3'd4 : cnt[2:0];
  endfunction

  logic [PKT_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG:0]   count;

  logic [3:0]           lane_vld;
  logic [PKT_W-1:0]     lane_pkt [4];
  logic [2:0]           lane_off [4];
  logic [2:0]           n_enq;
  logic [2:0]           n_enq_eff;
  logic [2:0]           n_deq;
  logic                 stall;
  logic                 enq_en;
  logic [DEPTH_LOG+1:0] occ_wide;
  logic [DEPTH_LOG:0]   count_next;
  logic [PKT_W-1:0]     slot_pkt [4];

  assign lane_vld    = {instruction3Valid_i, instruction2Valid_i,
                        instruction1Valid_i, instruction0Valid_i};
  assign lane_pkt[0] = inst0Packet_i;
  assign lane_pkt[1] = inst1Packet_i;
  assign lane_pkt[2] = inst2Packet_i;
  assign lane_pkt[3] = inst3Packet_i;

  // Back-pressure comes only from registered occupancy.
  assign stall  = (DEPTH_C - count) < FOUR_C;
  assign enq_en = !stall && !flush_i && !reset;

  // Each valid lane lands after all older valid lanes of the same group.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_off[i] = popcount4(lane_vld & 4'((1 << i) - 1));
    end
  end

  assign n_enq      = popcount4(lane_vld);
  assign n_enq_eff  = enq_en ? n_enq : 3'd0;
  assign n_deq      = decodeStall_i ? 3'd0 : deq_limit(count);
  assign occ_wide   = {1'b0, count} + (DEPTH_LOG+2)'(n_enq_eff)
                    - (DEPTH_LOG+2)'(n_deq);
  assign count_next = occ_wide[DEPTH_LOG:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + DEPTH_LOG'(n_deq);
      tail  <= tail + DEPTH_LOG'(n_enq_eff);
      count <= count_next;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_vld[i]) begin
          mem[tail + DEPTH_LOG'(lane_off[i])] <= lane_pkt[i];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot_pkt[k] = mem[head + DEPTH_LOG'(k)];
    end
  end

  assign inst0Packet_o       = slot_pkt[0];
  assign inst1Packet_o       = slot_pkt[1];
  assign inst2Packet_o       = slot_pkt[2];
  assign inst3Packet_o       = slot_pkt[3];
  assign instruction0Valid_o = count > (DEPTH_LOG+1)'(0);
  assign instruction1Valid_o = count > (DEPTH_LOG+1)'(1);
  assign instruction2Valid_o = count > (DEPTH_LOG+1)'(2);
  assign instruction3Valid_o = count > (DEPTH_LOG+1)'(3);
  assign stall_o             = stall;
  assign count_o             = count;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !flush_i) begin
      assert ((DEPTH_LOG+1)'(n_deq) <= count);
      assert (occ_wide <= (DEPTH_LOG+2)'(DEPTH));
    end
  end
`endif

endmodule
